match_line_builder: RTL and testbench
=====================================

// Module: match_line_builder
//
// PURPOSE
//   Inverse of the CAM priority encoder: rebuilds a one-hot-per-entry match_line
//   vector from a stream of entry indices. Upstream (search replay / software
//   injection path) sends indices one per beat; the block ORs each decoded index
//   into a mask and, on the beat marked last, presents the completed match_line
//   plus hit count and a duplicate flag to the CAM result path.
//
// PARAMETERS
//   MUX_WIDTH   16                  number of CAM entries = match_line width
//   MUX_INDEX   $clog2(MUX_WIDTH)   localparam, index width (not overridable)
//
// PORTS
//   clk             in   1              clock, all state on rising edge
//   rst             in   1              asynchronous reset, active-high
//   in_valid        in   1              index beat valid
//   in_ready        out  1              block can accept an index beat
//   in_index        in   MUX_INDEX      entry index to set in match_line
//   in_last         in   1              final index of current vector
//   out_valid       out  1              completed match_line available
//   out_ready       in   1              consumer accepts match_line
//   out_match_line  out  MUX_WIDTH      accumulated mask, bit i = entry i hit
//   out_count       out  MUX_INDEX+1    number of distinct bits set (0..MUX_WIDTH)
//   out_dup         out  1              some index arrived more than once
//   out_oor         out  1              some index >= MUX_WIDTH arrived
//
// BEHAVIOUR
//   - Reset (async, any time incl. mid-vector or while out_valid): state=COLLECT,
//     mask=0, count=0, dup=0, oor=0, out_valid=0; in_ready=1 from first edge after
//     rst deasserts. Partial vector is discarded, never emitted.
//   - States: COLLECT (in_ready=1, out_valid=0), EMIT (in_ready=0, out_valid=1).
//   - COLLECT, beat accepted (in_valid&&in_ready):
//       idx<MUX_WIDTH, bit clear: mask[idx]<=1, count<=count+1.
//       idx<MUX_WIDTH, bit set:   mask unchanged, count unchanged, dup<=1.
//       idx>=MUX_WIDTH (only possible if width not power of 2): mask/count
//         unchanged, oor<=1.
//       in_last=1: state<=EMIT; outputs reflect mask INCLUDING this beat's index.
//   - Latency: last beat accepted at edge N -> out_valid=1 after edge N, i.e.
//     visible in cycle N+1. No combinational in->out path; all outputs registered.
//   - EMIT: out_match_line/out_count/out_dup/out_oor held stable while
//     out_valid && !out_ready. On out_valid&&out_ready at edge M: mask, count, dup,
//     oor cleared, state<=COLLECT; in_ready=1 in cycle M+1 (no same-cycle bypass).
//   - in_valid ignored while in EMIT (in_ready=0); upstream must hold beat.
//   - Empty vector: single beat cannot express zero hits; a vector of one beat
//     yields exactly one bit set. count never exceeds MUX_WIDTH (saturation
//     structurally impossible since only new bits increment).
//   - Round-trip: priority encoding out_match_line returns the minimum index sent.
//
// TESTING
//   1. Reset, send idx 5 (last=1) -> next cycle out_valid=1, match_line=16'h0020,
//      count=1, dup=0; out_ready=1 -> in_ready=1 following cycle, regs cleared.
//   2. Send 3,9,15(last) -> match_line=16'h8208, count=3, dup=0; encoder gives 3.
//   3. Send 7,7,2(last) -> match_line=16'h0084, count=2, dup=1.
//   4. Send all 0..15 (last on 15) -> match_line=16'hFFFF, count=16; hold
//      out_ready=0 for 5 cycles -> outputs stable, in_ready=0, in_valid ignored.
//   5. Send 4,6 then assert rst mid-vector -> out_valid=0, mask=0; then send
//      1(last) -> match_line=16'h0002, count=1 (no residue of 4,6).
//   6. Back-to-back: vector A {0}(last) emitted with out_ready=1 continuously,
//      vector B {12}(last) offered immediately -> B accepted cycle after A's
//      handshake, B out = 16'h1000; no beat lost or merged.

Source files
------------

// File: rtl/match_line_builder.sv
// Rebuilds a CAM match_line from a stream of entry indices: each accepted beat ORs its
// decoded index into a mask, and the completed mask is presented when the last beat lands.
module match_line_builder #(
    parameter int MUX_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [$clog2(MUX_WIDTH)-1:0]         in_index,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [MUX_WIDTH-1:0]                 out_match_line,
    output logic [$clog2(MUX_WIDTH):0]           out_count,
    output logic                                 out_dup,
    output logic                                 out_oor
);

    localparam int MUX_INDEX = $clog2(MUX_WIDTH);
    localparam logic [MUX_INDEX:0] LP_WIDTH = (MUX_INDEX + 1)'(MUX_WIDTH);
    localparam logic [MUX_INDEX:0] LP_ONE   = {{MUX_INDEX{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [MUX_WIDTH-1:0]   r_mask;
    logic [MUX_WIDTH-1:0]   w_mask_nxt;
    logic [MUX_WIDTH-1:0]   w_onehot;
    logic [MUX_INDEX:0]     r_count;
    logic [MUX_INDEX:0]     w_count_nxt;
    logic                   r_dup;
    logic                   w_dup_nxt;
    logic                   r_oor;
    logic                   w_oor_nxt;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   w_accept;
    logic                   w_release;
    logic                   w_in_range;
    logic                   w_hit_set;

    assign w_accept   = in_valid && r_in_ready;
    assign w_release  = r_out_valid && out_ready;
    assign w_in_range = ({1'b0, in_index} < LP_WIDTH);
    assign w_onehot   = {{(MUX_WIDTH-1){1'b0}}, 1'b1} << in_index;
    assign w_hit_set  = |(r_mask & w_onehot);

    // Next-state and accumulator update; only a previously clear bit bumps the count.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_count_nxt = r_count;
        w_dup_nxt   = r_dup;
        w_oor_nxt   = r_oor;
        case (r_state)
            ST_COLLECT: begin
                if (w_accept) begin
                    if (!w_in_range) begin
                        w_oor_nxt = 1'b1;
                    end else if (w_hit_set) begin
                        w_dup_nxt = 1'b1;
                    end else begin
                        w_mask_nxt  = r_mask | w_onehot;
                        w_count_nxt = r_count + LP_ONE;
                    end
                    if (in_last) begin
                        w_state_nxt = ST_EMIT;
                    end else begin
                        w_state_nxt = ST_COLLECT;
                    end
                end else begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_EMIT: begin
                if (w_release) begin
                    w_state_nxt = ST_COLLECT;
                    w_mask_nxt  = {MUX_WIDTH{1'b0}};
                    w_count_nxt = {(MUX_INDEX+1){1'b0}};
                    w_dup_nxt   = 1'b0;
                    w_oor_nxt   = 1'b0;
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end
            default: begin
                w_state_nxt = ST_COLLECT;
                w_mask_nxt  = {MUX_WIDTH{1'b0}};
                w_count_nxt = {(MUX_INDEX+1){1'b0}};
                w_dup_nxt   = 1'b0;
                w_oor_nxt   = 1'b0;
            end
        endcase
    end

    // State and result registers; handshake flags are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_COLLECT;
            r_mask      <= {MUX_WIDTH{1'b0}};
            r_count     <= {(MUX_INDEX+1){1'b0}};
            r_dup       <= 1'b0;
            r_oor       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_count     <= w_count_nxt;
            r_dup       <= w_dup_nxt;
            r_oor       <= w_oor_nxt;
            r_in_ready  <= (w_state_nxt == ST_COLLECT);
            r_out_valid <= (w_state_nxt == ST_EMIT);
        end
    end

    assign in_ready       = r_in_ready;
    assign out_valid      = r_out_valid;
    assign out_match_line = r_mask;
    assign out_count      = r_count;
    assign out_dup        = r_dup;
    assign out_oor        = r_oor;

endmodule

// File: tb/tb_match_line_builder.sv
// Self-checking bench for match_line_builder: directed vector table, reset and
// back-to-back sequences, then random vectors against a set-based reference model.
module tb_match_line_builder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_index = 4'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_match_line;
    logic [4:0]  out_count;
    logic        out_dup;
    logic        out_oor;

    int n_vec  = 0;
    int n_miss = 0;

    match_line_builder #(.MUX_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_index       (in_index),
        .in_last        (in_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_match_line (out_match_line),
        .out_count      (out_count),
        .out_dup        (out_dup),
        .out_oor        (out_oor)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  n;
        logic [63:0] idxs;
        logic [15:0] mask;
        logic [4:0]  cnt;
        logic        dup;
        logic [3:0]  min_idx;
        logic [2:0]  hold;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: treat the vector as a set of entries.
    task automatic model(input logic [63:0] idxs, input int n,
                         output logic [15:0] mask, output logic [4:0] cnt,
                         output logic dup, output logic [3:0] min_idx);
        bit seen [16];
        int distinct = 0;
        int mn = 16;
        dup = 1'b0;
        for (int k = 0; k < 16; k++) seen[k] = 1'b0;
        for (int i = 0; i < n; i++) begin
            int v = int'(idxs[i*4 +: 4]);
            if (seen[v]) dup = 1'b1;
            else begin
                seen[v] = 1'b1;
                distinct++;
            end
            if (v < mn) mn = v;
        end
        mask = 16'd0;
        for (int k = 0; k < 16; k++) if (seen[k]) mask = mask + (16'd1 << k);
        cnt = 5'(distinct);
        min_idx = 4'(mn);
    endtask

    // Called at a negedge; returns at the negedge after the final beat's accepting edge.
    task automatic send_vector(input logic [63:0] idxs, input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            int budget = 0;
            in_valid = 1'b1;
            in_index = idxs[i*4 +: 4];
            in_last  = with_last && (i == n - 1);
            while (!in_ready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (budget >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (with_last) begin
            chk("latency_out_valid", 32'(out_valid), 32'd1);
            chk("emit_in_ready", 32'(in_ready), 32'd0);
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] m, input logic [4:0] c,
                              input logic d, input logic [3:0] mn, input int hold);
        int budget = 0;
        int pe = 16;
        while (!out_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_mask"},  32'(out_match_line), 32'(m));
        chk({tag, "_count"}, 32'(out_count), 32'(c));
        chk({tag, "_dup"},   32'(out_dup), 32'(d));
        chk({tag, "_oor"},   32'(out_oor), 32'd0);
        for (int k = 15; k >= 0; k--) if (out_match_line[k]) pe = k;
        chk({tag, "_prienc"}, 32'(pe), 32'(mn));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_index = 4'($urandom_range(0, 15));
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_mask"},  32'(out_match_line), 32'(m));
            chk({tag, "_hold_count"}, 32'(out_count), 32'(c));
            chk({tag, "_hold_rdy"},   32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rel_rdy"},   32'(in_ready), 32'd1);
        chk({tag, "_rel_clear"}, 32'({out_match_line, out_count, out_dup}), 32'd0);
    endtask

    initial begin
        vec_t tbl [4];
        logic [15:0] m;
        logic [4:0]  c;
        logic        d;
        logic [3:0]  mn;

        tbl[0] = '{n: 5'd1,  idxs: 64'h5,                   mask: 16'h0020, cnt: 5'd1,  dup: 1'b0, min_idx: 4'd5, hold: 3'd0};
        tbl[1] = '{n: 5'd3,  idxs: 64'hF93,                 mask: 16'h8208, cnt: 5'd3,  dup: 1'b0, min_idx: 4'd3, hold: 3'd1};
        tbl[2] = '{n: 5'd3,  idxs: 64'h277,                 mask: 16'h0084, cnt: 5'd2,  dup: 1'b1, min_idx: 4'd2, hold: 3'd0};
        tbl[3] = '{n: 5'd16, idxs: 64'hFEDC_BA98_7654_3210, mask: 16'hFFFF, cnt: 5'd16, dup: 1'b0, min_idx: 4'd0, hold: 3'd5};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_state", 32'({out_match_line, out_count, out_dup, out_oor}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int t = 0; t < 4; t++) begin
            send_vector(tbl[t].idxs, int'(tbl[t].n), 1'b1);
            expect_out($sformatf("tbl%0d", t), tbl[t].mask, tbl[t].cnt, tbl[t].dup,
                       tbl[t].min_idx, int'(tbl[t].hold));
        end

        // Reset lands mid-vector; the partial 4,6 must leave no residue.
        send_vector(64'h64, 2, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_mask", 32'(out_match_line), 32'd0);
        chk("midrst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_vector(64'h1, 1, 1'b1);
        expect_out("midrst_after", 16'h0002, 5'd1, 1'b0, 4'd1, 0);

        // Back-to-back: B offered while A is still being emitted.
        out_ready = 1'b1;
        in_valid = 1'b1; in_index = 4'd0; in_last = 1'b1;
        @(negedge clk);
        chk("b2b_a_valid", 32'(out_valid), 32'd1);
        chk("b2b_a_mask", 32'(out_match_line), 32'h0001);
        in_index = 4'd12;
        @(negedge clk);
        chk("b2b_gap_valid", 32'(out_valid), 32'd0);
        chk("b2b_gap_rdy", 32'(in_ready), 32'd1);
        chk("b2b_gap_mask", 32'(out_match_line), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        chk("b2b_b_valid", 32'(out_valid), 32'd1);
        chk("b2b_b_mask", 32'(out_match_line), 32'h1000);
        chk("b2b_b_count", 32'(out_count), 32'd1);
        expect_out("b2b_b", 16'h1000, 5'd1, 1'b0, 4'd12, 0);

        for (int r = 0; r < 30; r++) begin
            logic [63:0] idxs = 64'd0;
            int n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) idxs[i*4 +: 4] = 4'($urandom_range(0, 15));
            model(idxs, n, m, c, d, mn);
            send_vector(idxs, n, 1'b1);
            expect_out($sformatf("rnd%0d", r), m, c, d, mn, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
